// File: rtl/decode_pkg.sv
// Shared decode-stage constants: lane geometry, payload field layout, format one-hots.
// Latency: none (constants only).
// Backpressure: not applicable.
package decode_pkg;

    localparam int NUM_LANES       = 4;
    localparam int LANE_ID_WIDTH   = $clog2(NUM_LANES);
    localparam int PAYLOAD_WIDTH   = 192;
    localparam int FIFO_DEPTH      = 2;
    localparam int INSTR_CNT_WIDTH = 64;

    // Payload field layout, LSB positions and widths (body sits at the bottom).
    localparam int BODY_LSB        = 0;
    localparam int BODY_WIDTH      = 64;
    localparam int OPND_ISREG_LSB  = 64;   // one isReg flag per operand slot
    localparam int OPND_RW_LSB     = 68;   // one read/write flag per operand slot
    localparam int OPND_FLAG_WIDTH = 4;
    localparam int ID_LSB          = 72;   // four operand IDs, rd/rs1/rs2/rs3
    localparam int ID_WIDTH        = 20;
    localparam int NUM_IDS         = 4;
    localparam int UNIT_LSB        = 152;
    localparam int UNIT_WIDTH      = 3;
    localparam int OPCODE_LSB      = 155;
    localparam int OPCODE_WIDTH    = 12;
    localparam int FORMAT_LSB      = 167;
    localparam int FORMAT_WIDTH    = 25;

    // Instruction format one-hots, shared with the decoder instances.
    localparam logic [FORMAT_WIDTH-1:0] FMT_R = 25'h000_0001;
    localparam logic [FORMAT_WIDTH-1:0] FMT_I = 25'h000_0002;
    localparam logic [FORMAT_WIDTH-1:0] FMT_S = 25'h000_0004;
    localparam logic [FORMAT_WIDTH-1:0] FMT_B = 25'h000_0008;
    localparam logic [FORMAT_WIDTH-1:0] FMT_U = 25'h000_0010;
    localparam logic [FORMAT_WIDTH-1:0] FMT_J = 25'h000_0020;

endpackage

// File: rtl/decode_lane_fifo.sv
// Per-lane FIFO holding {majID, payload} entries; head is visible combinationally.
// Latency: an entry pushed at edge N is at the head after edge N.
// Backpressure: caller must not push when full nor pop when empty; flush empties it.
module decode_lane_fifo #(
    parameter int depth = 2,
    parameter int width = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [width-1:0]             push_data,
    input  logic                         pop,
    output logic [width-1:0]             head_data,
    output logic [$clog2(depth):0]       count,
    output logic                         full,
    output logic                         empty
);
    localparam int ptrWidth = $clog2(depth);
    localparam int cntWidth = ptrWidth + 1;

    logic [width-1:0]    mem [depth];
    logic [ptrWidth-1:0] wr_ptr;
    logic [ptrWidth-1:0] rd_ptr;

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates what is ever read out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == cntWidth'(depth));
    assign empty     = (count == '0);

endmodule

// File: rtl/decode_lane_arbiter.sv
// Round-robin merge of numLanes decode lanes into one registered valid/ready dispatch port.
// Latency: 2 cycles minimum from lane enable to out_valid_o (FIFO then output register).
// Backpressure: out_ready_i low freezes the output stage; lane_ready_o drops when a lane FIFO fills.
module decode_lane_arbiter
    import decode_pkg::*;
#(
    parameter int numLanes                = NUM_LANES,
    parameter int laneIdWidth             = LANE_ID_WIDTH,
    parameter int payloadWidth            = PAYLOAD_WIDTH,
    parameter int fifoDepth               = FIFO_DEPTH,
    parameter int instructionCounterWidth = INSTR_CNT_WIDTH
) (
    input  logic                                    clock_i,
    input  logic                                    reset_ni,
    input  logic                                    flush_i,
    input  logic [numLanes-1:0]                     lane_enable_i,
    input  logic [numLanes*instructionCounterWidth-1:0] lane_majId_i,
    input  logic [numLanes*payloadWidth-1:0]        lane_payload_i,
    output logic [numLanes-1:0]                     lane_ready_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [laneIdWidth-1:0]                  out_lane_o,
    output logic [instructionCounterWidth-1:0]      out_majId_o,
    output logic [payloadWidth-1:0]                 out_payload_o,
    output logic [numLanes-1:0]                     lane_overflow_o
);
    localparam int entryWidth = instructionCounterWidth + payloadWidth;
    localparam int cntWidth   = $clog2(fifoDepth) + 1;

    logic [cntWidth-1:0]    lane_count [numLanes];
    logic [entryWidth-1:0]  lane_head  [numLanes];
    logic [numLanes-1:0]    lane_full;
    logic [numLanes-1:0]    lane_empty;
    logic [numLanes-1:0]    lane_push;
    logic [numLanes-1:0]    lane_pop;
    logic [laneIdWidth-1:0] rr;
    logic [laneIdWidth-1:0] winner;
    logic                   grant;
    logic                   load;

    // Lane index a+b wrapped into 0..numLanes-1 (numLanes need not be a power of two).
    function automatic logic [laneIdWidth-1:0] lane_add(input logic [laneIdWidth-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= numLanes) s = s - numLanes;
        return laneIdWidth'(s);
    endfunction

    for (genvar k = 0; k < numLanes; k++) begin : g_lane
        logic [entryWidth-1:0] lane_entry;

        // Lane 0 occupies the MSB slice of the packed input buses.
        assign lane_entry = {lane_majId_i[(numLanes-1-k)*instructionCounterWidth +: instructionCounterWidth],
                             lane_payload_i[(numLanes-1-k)*payloadWidth +: payloadWidth]};

        // Ready looks at the registered count only, so a full lane stays not-ready while being popped.
        assign lane_ready_o[k] = (lane_count[k] < cntWidth'(fifoDepth));
        assign lane_push[k]    = lane_enable_i[k] && lane_ready_o[k] && !flush_i;
        assign lane_pop[k]     = grant && (winner == laneIdWidth'(k)) && !flush_i;

        decode_lane_fifo #(
            .depth (fifoDepth),
            .width (entryWidth)
        ) u_fifo (
            .clk       (clock_i),
            .rst_n     (reset_ni),
            .flush     (flush_i),
            .push      (lane_push[k]),
            .push_data (lane_entry),
            .pop       (lane_pop[k]),
            .head_data (lane_head[k]),
            .count     (lane_count[k]),
            .full      (lane_full[k]),
            .empty     (lane_empty[k])
        );
    end

    assign load = !out_valid_o || out_ready_i;

    // Pick the first non-empty lane starting at rr; only meaningful when the output can load.
    always_comb begin
        grant  = 1'b0;
        winner = rr;
        if (load) begin
            for (int i = 0; i < numLanes; i++) begin
                if (!grant && !lane_empty[lane_add(rr, i)]) begin
                    grant  = 1'b1;
                    winner = lane_add(rr, i);
                end
            end
        end
    end

    // Round-robin pointer advances past the winner; flush keeps it.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr <= '0;
        end else if (!flush_i && grant) begin
            rr <= lane_add(winner, 1);
        end
    end

    // Output register: flush drops it, otherwise loads the winner or empties when nothing is pending.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid_o   <= 1'b0;
            out_lane_o    <= '0;
            out_majId_o   <= '0;
            out_payload_o <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (load) begin
            if (grant) begin
                out_valid_o                  <= 1'b1;
                out_lane_o                   <= winner;
                {out_majId_o, out_payload_o} <= lane_head[winner];
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

    // Sticky overflow: an enable that arrives while the lane is full is lost.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lane_overflow_o <= '0;
        end else begin
            lane_overflow_o <= lane_overflow_o | (lane_enable_i & lane_full);
        end
    end

endmodule

// File: tb/tb_decode_lane_arbiter.sv
module tb_decode_lane_arbiter;
    localparam int NL = 4;
    localparam int LW = 2;
    localparam int PW = 192;
    localparam int MW = 64;
    localparam int DEPTH = 2;

    typedef logic [MW+PW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic ordy;
    logic [NL-1:0] en;
    logic [MW-1:0] maj [NL];
    logic [PW-1:0] pay [NL];
    logic [NL*MW-1:0] maj_bus;
    logic [NL*PW-1:0] pay_bus;

    logic [NL-1:0] lane_ready;
    logic          out_valid;
    logic [LW-1:0] out_lane;
    logic [MW-1:0] out_maj;
    logic [PW-1:0] out_pay;
    logic [NL-1:0] lane_ovf;

    // Reference model state
    ent_t        q [NL][$];
    int          m_rr;
    bit          m_vld;
    int          m_lane;
    logic [MW-1:0] m_maj;
    logic [PW-1:0] m_pay;
    logic [NL-1:0] m_ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        maj_bus = '0;
        pay_bus = '0;
        for (int k = 0; k < NL; k++) begin
            maj_bus[(NL-1-k)*MW +: MW] = maj[k];
            pay_bus[(NL-1-k)*PW +: PW] = pay[k];
        end
    end

    decode_lane_arbiter #(
        .numLanes(NL), .laneIdWidth(LW), .payloadWidth(PW),
        .fifoDepth(DEPTH), .instructionCounterWidth(MW)
    ) dut (
        .clock_i         (clk),
        .reset_ni        (rst_n),
        .flush_i         (flush),
        .lane_enable_i   (en),
        .lane_majId_i    (maj_bus),
        .lane_payload_i  (pay_bus),
        .lane_ready_o    (lane_ready),
        .out_valid_o     (out_valid),
        .out_ready_i     (ordy),
        .out_lane_o      (out_lane),
        .out_majId_o     (out_maj),
        .out_payload_o   (out_pay),
        .lane_overflow_o (lane_ovf)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pay();
        logic [PW-1:0] r;
        for (int i = 0; i < PW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rnd_data();
        for (int k = 0; k < NL; k++) begin
            maj[k] = {$urandom, $urandom};
            pay[k] = rnd_pay();
        end
    endtask

    function automatic logic [NL-1:0] model_ready();
        logic [NL-1:0] r;
        for (int k = 0; k < NL; k++) r[k] = (q[k].size() < DEPTH);
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NL; k++) q[k].delete();
        m_rr = 0; m_vld = 0; m_lane = 0; m_maj = '0; m_pay = '0; m_ovf = '0;
    endtask

    // One clock edge of the specified behaviour, from the inputs held before the edge.
    task automatic model_edge();
        logic [NL-1:0] rdy;
        bit got;
        ent_t e;
        int j;
        rdy = model_ready();
        if (flush) begin
            for (int k = 0; k < NL; k++) begin
                if (en[k] && !rdy[k]) m_ovf[k] = 1'b1;
                q[k].delete();
            end
            m_vld = 0;
        end else begin
            if (!m_vld || ordy) begin
                got = 0;
                for (int i = 0; i < NL; i++) begin
                    j = (m_rr + i) % NL;
                    if (!got && q[j].size() > 0) begin
                        e = q[j].pop_front();
                        m_vld = 1; m_lane = j;
                        m_maj = e[MW+PW-1:PW]; m_pay = e[PW-1:0];
                        m_rr = (j + 1) % NL;
                        got = 1;
                    end
                end
                if (!got) m_vld = 0;
            end
            for (int k = 0; k < NL; k++) begin
                if (en[k]) begin
                    if (rdy[k]) q[k].push_back({maj[k], pay[k]});
                    else m_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 256'(out_valid), 256'(m_vld));
        if (m_vld) begin
            chk("out_lane", 256'(out_lane), 256'(m_lane));
            chk("out_majId", 256'(out_maj), 256'(m_maj));
            chk("out_payload", 256'(out_pay), 256'(m_pay));
        end
        chk("lane_ready", 256'(lane_ready), 256'(model_ready()));
        chk("lane_overflow", 256'(lane_ovf), 256'(m_ovf));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_lane"}, 256'(out_lane), 256'(0));
        chk({tag, "_majId"}, 256'(out_maj), 256'(0));
        chk({tag, "_payload"}, 256'(out_pay), 256'(0));
        chk({tag, "_ready"}, 256'(lane_ready), 256'(4'b1111));
        chk({tag, "_overflow"}, 256'(lane_ovf), 256'(0));
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        en = '0; flush = 1'b0;
        chk_reset_state(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int exp_order [8];
        int rr_before;
        rst_n = 1'b1; flush = 1'b0; ordy = 1'b1; en = '0;
        rnd_data();
        model_clear();
        #1 rst_n = 1'b0;
        #3;
        chk_reset_state("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single lane, in-order with 2-cycle latency
        ordy = 1'b1;
        en = 4'b0010; maj[1] = 64'd10; step();
        chk("lat_not_yet", 256'(out_valid), 256'(0));
        maj[1] = 64'd11; step();
        chk("lat_first_valid", 256'(out_valid), 256'(1));
        chk("lat_first_maj", 256'(out_maj), 256'(10));
        chk("lat_first_lane", 256'(out_lane), 256'(1));
        maj[1] = 64'd12; step();
        chk("single_second", 256'(out_maj), 256'(11));
        en = '0; step();
        chk("single_third", 256'(out_maj), 256'(12));
        step(); step();

        // Fairness from rr = 0 with every lane holding two entries
        do_reset("reset_fair");
        ordy = 1'b0; en = 4'b1111;
        rnd_data(); step();
        rnd_data(); step();
        en = '0;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk("fair_0", 256'(out_lane), 256'(exp_order[0]));
        ordy = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("fair_order", 256'(out_lane), 256'(exp_order[i]));
        end
        step();
        chk("fair_rr_end", 256'(m_rr), 256'(0));

        // Back-pressure on lane 3 behind a stalled lane-2 output
        ordy = 1'b0;
        en = 4'b0100; maj[2] = 64'h2222; step();
        en = '0; step();
        chk("bp_held_lane", 256'(out_lane), 256'(2));
        for (int i = 0; i < 3; i++) begin
            en = 4'b1000; maj[3] = 64'(30 + i); pay[3] = rnd_pay(); step();
            chk("bp_frozen", 256'(out_maj), 256'(64'h2222));
            if (i == 1) chk("bp_ready3_low", 256'(lane_ready[3]), 256'(0));
        end
        chk("bp_overflow3", 256'(lane_ovf[3]), 256'(1));
        en = '0; step();
        chk("bp_frozen_last", 256'(out_maj), 256'(64'h2222));
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Flush with lanes 0 and 1 full and the output valid
        ordy = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (!(q[0].size() == DEPTH && q[1].size() == DEPTH && m_vld)) begin
                rnd_data();
                en = {2'b00, q[1].size() < DEPTH, q[0].size() < DEPTH};
                step();
            end
        end
        chk("flush_pre_valid", 256'(out_valid), 256'(1));
        rr_before = m_rr;
        flush = 1'b1; en = 4'b0100; maj[2] = 64'hDEAD; step();
        flush = 1'b0; en = '0;
        chk("flush_valid", 256'(out_valid), 256'(0));
        chk("flush_ready", 256'(lane_ready), 256'(4'b1111));
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_emit", 256'(out_valid), 256'(0));
        end
        en = 4'b1111; rnd_data(); step();
        en = '0; step();
        chk("flush_rr_kept", 256'(out_lane), 256'(rr_before));
        for (int i = 0; i < 4; i++) step();

        // Full lane 0 popped while its enable is refused
        ordy = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (!(q[0].size() == DEPTH && m_vld)) begin
                rnd_data();
                en = {3'b000, q[0].size() < DEPTH};
                step();
            end
        end
        chk("full_pre_ovf0", 256'(lane_ovf[0]), 256'(0));
        ordy = 1'b1; en = 4'b0001; rnd_data(); step();
        chk("full_ovf0", 256'(lane_ovf[0]), 256'(1));
        chk("full_ready0", 256'(lane_ready[0]), 256'(1));
        en = '0;
        for (int i = 0; i < 3; i++) step();

        // Reset in the middle of traffic on lanes 0 and 2
        ordy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            rnd_data();
            en = {1'b0, q[2].size() < DEPTH, 1'b0, q[0].size() < DEPTH};
            step();
        end
        do_reset("reset_mid");
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_no_emit", 256'(out_valid), 256'(0));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rnd_data();
            en = 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0; en = '0; ordy = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
